// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and mixer FSM state type
package audio_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int VOLUME_BITS = 8;
    localparam int BUF_LEN     = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SAT   = 2'd2,
        ST_WRITE = 2'd3
    } mix_state_t;

endpackage

// File: rtl/lrclk_tick_sync.sv
// rtl/lrclk_tick_sync.sv - lrclk 2-flop synchronizer with falling-edge tick
module lrclk_tick_sync (
    input  logic clk,
    input  logic rstn,
    input  logic lrclk,
    output logic tick
);

    logic meta;
    logic sync;
    logic prev;

    // Flops reset high so a line already idling high never fakes an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= lrclk;
            sync <= meta;
            prev <= sync;
        end
    end

    assign tick = prev & ~sync;

endmodule

// File: rtl/sample_mixer.sv
// rtl/sample_mixer.sv - per-frame weighted mix of sources into the playback ring buffer
module sample_mixer #(
    parameter int NUM_SOURCES = 2,
    parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int VOLUME_BITS = audio_pkg::VOLUME_BITS,
    parameter int BUF_LEN     = audio_pkg::BUF_LEN,
    parameter int LAG         = 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 lrclk,
    input  logic                                 enable,
    input  logic [NUM_SOURCES*SAMPLE_BITS-1:0]   src_sample,
    input  logic [NUM_SOURCES-1:0]               src_valid,
    input  logic [NUM_SOURCES*VOLUME_BITS-1:0]   src_vol,
    input  logic [$clog2(BUF_LEN)-1:0]           rd_index,
    output logic                                 wr_en,
    output logic [$clog2(BUF_LEN)-1:0]           wr_addr,
    output logic [SAMPLE_BITS-1:0]               wr_data,
    output logic                                 busy,
    output logic                                 clip,
    output logic [15:0]                          overrun_cnt
);

    localparam int AW   = $clog2(BUF_LEN);
    localparam int CW   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int PW   = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam int ACCW = SAMPLE_BITS + $clog2(NUM_SOURCES) + 1;

    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN =
        {{(ACCW-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

    audio_pkg::mix_state_t state, state_next;

    logic                                tick;
    logic [CW-1:0]                       idx;
    logic signed [ACCW-1:0]              acc;
    logic [NUM_SOURCES*SAMPLE_BITS-1:0]  sample_cap;
    logic [NUM_SOURCES-1:0]              valid_cap;
    logic [NUM_SOURCES*VOLUME_BITS-1:0]  vol_cap;
    logic [AW-1:0]                       index_cap;

    logic signed [SAMPLE_BITS-1:0]       cur_sample;
    logic [VOLUME_BITS-1:0]              cur_vol;
    logic                                cur_valid;
    logic signed [PW-1:0]                sample_ext;
    logic signed [PW-1:0]                vol_ext;
    logic signed [PW-1:0]                product;
    logic signed [PW-1:0]                scaled;
    logic signed [ACCW-1:0]              contrib;
    logic                                last_src;
    logic [SAMPLE_BITS-1:0]              sat_val;
    logic                                sat_hit;

    lrclk_tick_sync u_tick_sync (
        .clk   (clk),
        .rstn  (rstn),
        .lrclk (lrclk),
        .tick  (tick)
    );

    always_comb begin
        cur_sample = '0;
        cur_vol    = '0;
        cur_valid  = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (idx == CW'(i)) begin
                cur_sample = sample_cap[i*SAMPLE_BITS +: SAMPLE_BITS];
                cur_vol    = vol_cap[i*VOLUME_BITS +: VOLUME_BITS];
                cur_valid  = valid_cap[i];
            end
        end
    end

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    assign sample_ext = PW'(cur_sample);
    assign vol_ext    = $signed({{(PW-VOLUME_BITS){1'b0}}, cur_vol});
    assign product    = sample_ext * vol_ext;
    assign scaled     = product >>> VOLUME_BITS;
    assign contrib    = cur_valid ? ACCW'(scaled) : '0;
    assign last_src   = (idx == CW'(NUM_SOURCES - 1));

    always_comb begin
        sat_hit = 1'b0;
        sat_val = acc[SAMPLE_BITS-1:0];
        if (acc > SAT_MAX) begin
            sat_hit = 1'b1;
            sat_val = SAT_MAX[SAMPLE_BITS-1:0];
        end else if (acc < SAT_MIN) begin
            sat_hit = 1'b1;
            sat_val = SAT_MIN[SAMPLE_BITS-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            audio_pkg::ST_IDLE:  if (tick && enable) state_next = audio_pkg::ST_MAC;
            audio_pkg::ST_MAC:   if (last_src) state_next = audio_pkg::ST_SAT;
            audio_pkg::ST_SAT:   state_next = audio_pkg::ST_WRITE;
            audio_pkg::ST_WRITE: state_next = audio_pkg::ST_IDLE;
            default:             state_next = audio_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= audio_pkg::ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx         <= '0;
            acc         <= '0;
            sample_cap  <= '0;
            valid_cap   <= '0;
            vol_cap     <= '0;
            index_cap   <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            clip        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            case (state)
                audio_pkg::ST_IDLE: begin
                    if (tick && enable) begin
                        sample_cap <= src_sample;
                        valid_cap  <= src_valid;
                        vol_cap    <= src_vol;
                        index_cap  <= rd_index;
                        acc        <= '0;
                        idx        <= '0;
                    end
                end
                audio_pkg::ST_MAC: begin
                    acc <= acc + contrib;
                    idx <= idx + 1'b1;
                end
                audio_pkg::ST_SAT: begin
                    wr_data <= sat_val;
                    wr_addr <= index_cap - AW'(LAG);
                    if (sat_hit) clip <= 1'b1;
                end
                default: ;
            endcase

            if (tick && (state != audio_pkg::ST_IDLE) && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

    assign wr_en = (state == audio_pkg::ST_WRITE);
    assign busy  = (state != audio_pkg::ST_IDLE);

endmodule

// File: tb/tb_sample_mixer.sv
// tb/tb_sample_mixer.sv - directed self-checking bench for sample_mixer
module tb_sample_mixer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        lrclk = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] src_sample = '0;
    logic [1:0]  src_valid = '0;
    logic [15:0] src_vol = '0;
    logic [7:0]  rd_index = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        clip;
    logic [15:0] overrun_cnt;

    int checks = 0;
    int fails  = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    sample_mixer dut (
        .clk         (clk),
        .rstn        (rstn),
        .lrclk       (lrclk),
        .enable      (enable),
        .src_sample  (src_sample),
        .src_valid   (src_valid),
        .src_vol     (src_vol),
        .rd_index    (rd_index),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .clip        (clip),
        .overrun_cnt (overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [7:0] v0, input logic [7:0] v1,
                             input logic [1:0] val, input logic [7:0] ri);
        src_sample = {s1, s0};
        src_vol    = {v1, v0};
        src_valid  = val;
        rd_index   = ri;
    endtask

    // Drops lrclk once, then counts wr_en cycles; lat is negedges from the drop to the first strobe.
    task automatic run_frame(output int l, output int p);
        @(negedge clk);
        lrclk = 1'b0;
        l = 0;
        p = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                p++;
                if (l == 0) l = i;
            end
        end
        lrclk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) p++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        rstn   = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // 1000*128>>8 = 500, 2000*255>>8 = 1992
        set_frame(16'd1000, 16'd2000, 8'd128, 8'd255, 2'b11, 8'd10);
        run_frame(lat, pulses);
        check("a_latency", 32'(lat), 32'd6);
        check("a_pulses", 32'(pulses), 32'd1);
        check("a_wr_addr", 32'(wr_addr), 32'd9);
        check("a_wr_data", 32'(wr_data), 32'd2492);
        check("a_clip", 32'(clip), 32'd0);
        check("a_busy", 32'(busy), 32'd0);

        // 2 * 32639 overflows positive
        set_frame(16'h7FFF, 16'h7FFF, 8'd255, 8'd255, 2'b11, 8'd20);
        run_frame(lat, pulses);
        check("pos_sat_data", 32'(wr_data), 32'h7FFF);
        check("pos_sat_addr", 32'(wr_addr), 32'd19);
        check("pos_sat_clip", 32'(clip), 32'd1);

        // 2 * -32640 overflows negative
        set_frame(16'h8000, 16'h8000, 8'd255, 8'd255, 2'b11, 8'd21);
        run_frame(lat, pulses);
        check("neg_sat_data", 32'(wr_data), 32'h8000);
        check("neg_sat_clip", 32'(clip), 32'd1);

        set_frame(16'd1000, 16'd5000, 8'd128, 8'd255, 2'b01, 8'd0);
        run_frame(lat, pulses);
        check("wrap_addr", 32'(wr_addr), 32'd255);
        check("invalid_src_data", 32'(wr_data), 32'd500);

        // 100*255>>8 = 99, 200*255>>8 = 199; second tick lands mid-MAC
        set_frame(16'd100, 16'd200, 8'd255, 8'd255, 2'b11, 8'd50);
        @(negedge clk);
        lrclk = 1'b0;
        @(negedge clk);
        lrclk = 1'b1;
        @(negedge clk);
        lrclk = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) pulses++;
        end
        lrclk = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_pulses", 32'(pulses), 32'd1);
        check("ovr_count", 32'(overrun_cnt), 32'd1);
        check("ovr_data", 32'(wr_data), 32'd298);
        check("ovr_addr", 32'(wr_addr), 32'd49);

        enable = 1'b0;
        set_frame(16'd1000, 16'd2000, 8'd128, 8'd255, 2'b11, 8'd30);
        run_frame(lat, pulses);
        check("dis_pulses", 32'(pulses), 32'd0);
        check("dis_overrun", 32'(overrun_cnt), 32'd1);
        check("dis_hold_addr", 32'(wr_addr), 32'd49);
        enable = 1'b1;

        set_frame(16'd1000, 16'd1000, 8'd255, 8'd255, 2'b11, 8'd40);
        @(negedge clk);
        lrclk = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_clip", 32'(clip), 32'd0);
        check("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
        @(negedge clk);
        lrclk = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) pulses++;
        end
        check("mid_no_write", 32'(pulses), 32'd0);

        set_frame(16'd1000, 16'd2000, 8'd128, 8'd255, 2'b11, 8'd10);
        run_frame(lat, pulses);
        check("post_latency", 32'(lat), 32'd6);
        check("post_pulses", 32'(pulses), 32'd1);
        check("post_addr", 32'(wr_addr), 32'd9);
        check("post_data", 32'(wr_data), 32'd2492);
        check("post_clip", 32'(clip), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
